// File: rtl/flash_byte_reader.sv
// flash_byte_reader
// Fetches one byte at a time from an SPI NOR flash (READ 0x03, mode 0) for the
// cpu fetch path. Each request is a complete CS-framed transaction: 8 command
// bits, 24 address bits, then 8 data bits. There is no caching and no burst.
// The handshake is level based. The requester raises enable and holds it until
// dataReady is high. It must then drop enable for at least one cycle before it
// can make another request.

module flash_byte_reader #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10_000_000,
  parameter logic [7:0]  CLK_DIV      = 8'd1,
  parameter logic [23:0] BASE_ADDR    = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] readAddr,
  input  logic        enable,
  output logic        dataReady,
  output logic [7:0]  byteRead,
  output logic        flashClk,
  output logic        flashCs,
  output logic        flashMosi,
  input  logic        flashMiso
);

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    SHIFT_OUT,
    SHIFT_IN,
    DONE
  } state_t;

  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [5:0] LAST_OUT_BIT = 6'd31;
  localparam logic [5:0] LAST_BIT     = 6'd39;

  state_t      state_q, state_d;
  logic [31:0] startCnt_q, startCnt_d;
  logic [7:0]  divCnt_q, divCnt_d;
  logic [5:0]  bitCnt_q, bitCnt_d;
  logic [31:0] txShift_q, txShift_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic [7:0]  byte_q, byte_d;

  logic [23:0] reqAddr;
  logic        halfDone;
  logic        startDone;

  // The flash address wraps modulo 2^24 because only the low 24 bits of the sum are kept.
  assign reqAddr   = BASE_ADDR + {13'b0, readAddr};
  assign halfDone  = (divCnt_q == CLK_DIV - 8'd1);
  assign startDone = (startCnt_q == STARTUP_WAIT - 32'd1);

  assign dataReady = ready_q;
  assign byteRead  = byte_q;
  assign flashClk  = sck_q;
  assign flashCs   = cs_q;
  assign flashMosi = mosi_q;

  // State register. Reset is synchronous and parks the SPI bus with CS high and SCK low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= STARTUP;
      startCnt_q <= '0;
      divCnt_q   <= '0;
      bitCnt_q   <= '0;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      byte_q     <= '0;
    end else begin
      state_q    <= state_d;
      startCnt_q <= startCnt_d;
      divCnt_q   <= divCnt_d;
      bitCnt_q   <= bitCnt_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      byte_q     <= byte_d;
    end
  end

  // Next-state logic. The acceptance edge only latches the request. CS drops on the
  // following edge, so the bus is idle for at least two clocks between transactions.
  always_comb begin
    state_d    = state_q;
    startCnt_d = startCnt_q;
    divCnt_d   = divCnt_q;
    bitCnt_d   = bitCnt_q;
    txShift_d  = txShift_q;
    rxShift_d  = rxShift_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    byte_d     = byte_q;

    case (state_q)
      STARTUP: begin
        ready_d = 1'b0;
        if (startDone) begin
          startCnt_d = '0;
          if (enable) begin
            txShift_d = {CMD_READ, reqAddr};
            state_d   = SHIFT_OUT;
          end else begin
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          startCnt_d = startCnt_q + 32'd1;
        end
      end

      IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (enable) begin
          txShift_d = {CMD_READ, reqAddr};
          state_d   = SHIFT_OUT;
        end
      end

      SHIFT_OUT: begin
        if (cs_q) begin
          cs_d     = 1'b0;
          ready_d  = 1'b0;
          sck_d    = 1'b0;
          mosi_d   = txShift_q[31];
          divCnt_d = '0;
          bitCnt_d = '0;
        end else if (halfDone) begin
          divCnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d    = 1'b0;
            bitCnt_d = bitCnt_q + 6'd1;
            if (bitCnt_q == LAST_OUT_BIT) begin
              mosi_d  = 1'b0;
              state_d = SHIFT_IN;
            end else begin
              txShift_d = {txShift_q[30:0], 1'b0};
              mosi_d    = txShift_q[30];
            end
          end
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      SHIFT_IN: begin
        if (halfDone) begin
          divCnt_d = '0;
          if (!sck_q) begin
            sck_d     = 1'b1;
            rxShift_d = {rxShift_q[6:0], flashMiso};
          end else begin
            sck_d = 1'b0;
            if (bitCnt_q == LAST_BIT) begin
              cs_d    = 1'b1;
              byte_d  = rxShift_q;
              ready_d = 1'b1;
              state_d = DONE;
            end else begin
              bitCnt_d = bitCnt_q + 6'd1;
            end
          end
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      DONE: begin
        ready_d = 1'b1;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = STARTUP;
      end
    endcase
  end

endmodule
